// File: rtl/lane_deskew_if.sv
// Lane-side and word-side signals of the lane deskew receiver.
// The master drives the lanes and consumes words; the slave is the deskew block.
interface lane_deskew_if #(
  parameter int LANES  = 6,
  parameter int LANE_W = 2
);
  logic [LANES*LANE_W-1:0] lane_data;
  logic [LANES-1:0]        lane_valid;
  logic                    flush;
  logic [LANES*LANE_W-1:0] word_data;
  logic                    word_valid;
  logic                    word_ready;
  logic                    aligned;
  logic                    skew_err;
  logic [LANES-1:0]        ovf_err;

  modport master (
    output lane_data, lane_valid, flush, word_ready,
    input  word_data, word_valid, aligned, skew_err, ovf_err
  );

  modport slave (
    input  lane_data, lane_valid, flush, word_ready,
    output word_data, word_valid, aligned, skew_err, ovf_err
  );
endinterface

// File: rtl/lane_deskew_rx.sv
// Multi-lane receive deskew: per-lane FIFOs absorb arrival skew, and one entry
// from every lane is popped together into a registered output word.
module lane_deskew_rx #(
  parameter int LANES    = 6,
  parameter int LANE_W   = 2,
  parameter int DEPTH    = 8,
  parameter int MAX_SKEW = 4
) (
  input logic          clk,
  input logic          rst_n,
  lane_deskew_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_SKEW + 1);
  localparam int WW = LANES * LANE_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     skew_cnt_q, skew_cnt_d;
  logic              word_valid_q, word_valid_d;
  logic [WW-1:0]     word_data_q, word_data_d;
  logic              skew_err_q, skew_err_d;
  logic              aligned_q;
  logic [LANES-1:0]  ovf_err_q, ovf_err_d;
  logic [PW-1:0]     wr_ptr_q [LANES];
  logic [PW-1:0]     wr_ptr_d [LANES];
  logic [PW-1:0]     rd_ptr_q [LANES];
  logic [PW-1:0]     rd_ptr_d [LANES];
  logic [LANE_W-1:0] mem_q [LANES][DEPTH];

  logic [LANES-1:0]  empty, full, wr_req, wr_en, ovf_hit;
  logic              all_ne, out_free, pop;
  logic [WW-1:0]     pop_word;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    pop_word = '0;
    empty    = '0;
    full     = '0;
    for (int i = 0; i < LANES; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      pop_word[i*LANE_W +: LANE_W] = mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  assign all_ne   = ~|empty;
  assign out_free = !word_valid_q || bus.word_ready;
  assign pop      = ((state_q == S_WAIT) || (state_q == S_RUN)) && all_ne && out_free;
  assign wr_req   = (state_q != S_ERR) ? bus.lane_valid : '0;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = wr_req & (~full | {LANES{pop}});
  assign ovf_hit  = wr_req & full & ~{LANES{pop}};

  always_comb begin
    state_d      = state_q;
    skew_cnt_d   = skew_cnt_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    skew_err_d   = skew_err_q;
    ovf_err_d    = ovf_err_q | ovf_hit;
    for (int i = 0; i < LANES; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(wr_en[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop);
    end

    if (pop) begin
      word_valid_d = 1'b1;
      word_data_d  = pop_word;
    end else if (word_valid_q && bus.word_ready) begin
      word_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (|bus.lane_valid) begin
          state_d    = S_WAIT;
          skew_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (all_ne) begin
          state_d = S_RUN;
        end else if (skew_cnt_q == CW'(MAX_SKEW)) begin
          state_d    = S_ERR;
          skew_err_d = 1'b1;
        end else begin
          skew_cnt_d = skew_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (|ovf_hit) state_d = S_ERR;
    if (state_d == S_ERR) word_valid_d = 1'b0;

    if (bus.flush) begin
      state_d      = S_IDLE;
      skew_cnt_d   = '0;
      word_valid_d = 1'b0;
      skew_err_d   = 1'b0;
      ovf_err_d    = '0;
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      skew_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      skew_err_q   <= 1'b0;
      ovf_err_q    <= '0;
      aligned_q    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      skew_cnt_q   <= skew_cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      skew_err_q   <= skew_err_d;
      ovf_err_q    <= ovf_err_d;
      aligned_q    <= (state_d == S_RUN);
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // FIFO storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i] && !bus.flush)
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.lane_data[i*LANE_W +: LANE_W];
    end
  end

  assign bus.word_data  = word_data_q;
  assign bus.word_valid = word_valid_q;
  assign bus.aligned    = aligned_q;
  assign bus.skew_err   = skew_err_q;
  assign bus.ovf_err    = ovf_err_q;
endmodule

// File: tb/tb_lane_deskew_rx.sv
// Scoreboard bench for lane_deskew_rx: expected words are queued when driven
// and compared in order as the DUT hands them over.
module tb_lane_deskew_rx;
  localparam int LANES = 6;
  localparam int LANE_W = 2;
  localparam int W = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst_n;
  lane_deskew_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  lane_deskew_rx #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(8), .MAX_SKEW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  logic [W-1:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [7:0] k);
    logic [W-1:0] w;
    w[1:0]   = k[1:0];
    w[3:2]   = k[3:2];
    w[5:4]   = k[5:4];
    w[7:6]   = ~k[1:0];
    w[9:8]   = k[1:0] ^ k[3:2];
    w[11:10] = k[2:1];
    return w;
  endfunction

  // Words are handed over at the edge following a cycle with valid && ready.
  always @(negedge clk) begin
    if (rst_n && !bus.flush && bus.word_valid && bus.word_ready) begin
      n_acc++;
      if (sb.size() == 0) check_eq("unexp_word_valid", 32'(bus.word_valid), 32'd0);
      else check_eq("word_data", 32'(bus.word_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [LANES-1:0] mask, input logic [W-1:0] data);
    bus.lane_valid = mask;
    bus.lane_data  = data;
  endtask

  task automatic idle();
    bus.lane_valid = '0;
    bus.lane_data  = '0;
  endtask

  task automatic do_flush();
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    int i = 0;
    bus.word_ready = 1'b1;
    while (sb.size() != 0 && i < 60) begin
      tick();
      i++;
    end
    check_eq(tag, sb.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    bit seen;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.word_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_word_valid", 32'(bus.word_valid), 0);
    check_eq("rst_word_data", 32'(bus.word_data), 0);
    check_eq("rst_aligned", 32'(bus.aligned), 0);
    check_eq("rst_skew_err", 32'(bus.skew_err), 0);
    check_eq("rst_ovf_err", 32'(bus.ovf_err), 0);
    rst_n = 1'b1;
    tick();

    // All lanes together: word two cycles later
    bus.word_ready = 1'b1;
    d = 12'b10_01_00_11_10_01;
    drive('1, d);
    sb.push_back(d);
    @(negedge clk) check_eq("lat_c0_valid", 32'(bus.word_valid), 0);
    tick(); idle();
    @(negedge clk) check_eq("lat_c1_valid", 32'(bus.word_valid), 0);
    tick();
    @(negedge clk);
    check_eq("lat_c2_valid", 32'(bus.word_valid), 1);
    check_eq("lat_c2_data", 32'(bus.word_data), 32'h939);
    check_eq("lat_c2_aligned", 32'(bus.aligned), 1);
    drain("drain_basic");

    // One cycle of skew between lane groups
    do_flush();
    d = word_of(8'd5);
    drive(6'b001111, d);
    tick();
    drive(6'b110000, d);
    sb.push_back(d);
    tick(); idle();
    @(negedge clk) check_eq("skew1_c2_valid", 32'(bus.word_valid), 0);
    tick();
    @(negedge clk) check_eq("skew1_c3_valid", 32'(bus.word_valid), 1);
    drain("drain_skew1");
    check_eq("skew1_no_err", 32'(bus.skew_err), 0);

    // Lane 5 never arrives
    do_flush();
    seen = 1'b0;
    drive(6'b011111, word_of(8'd9));
    tick(); idle();
    for (int c = 1; c < 14; c++) begin
      @(negedge clk);
      if (bus.word_valid) seen = 1'b1;
      if (c == 4) check_eq("skew_not_yet", 32'(bus.skew_err), 0);
      tick();
    end
    check_eq("skew_err_set", 32'(bus.skew_err), 1);
    check_eq("skew_not_aligned", 32'(bus.aligned), 0);
    check_eq("skew_no_word", 32'(seen), 0);
    do_flush();
    check_eq("flush_clr_skew", 32'(bus.skew_err), 0);
    check_eq("flush_idle", 32'(bus.aligned), 0);

    // Overflow of lane 2 while output is stalled
    bus.word_ready = 1'b0;
    drive('1, word_of(8'd20));
    tick();
    for (int k = 0; k < 8; k++) begin
      drive('1, word_of(8'(21 + k)));
      tick();
    end
    drive(6'b000100, word_of(8'd30));
    tick(); idle();
    @(negedge clk);
    check_eq("ovf_err", 32'(bus.ovf_err), 32'h04);
    check_eq("ovf_word_valid", 32'(bus.word_valid), 0);
    check_eq("ovf_not_aligned", 32'(bus.aligned), 0);
    tick();
    do_flush();
    check_eq("flush_clr_ovf", 32'(bus.ovf_err), 0);

    // Full FIFOs: pop and write in the same cycle
    bus.word_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive('1, word_of(8'(32 + k)));
      sb.push_back(word_of(8'(32 + k)));
      tick();
    end
    bus.word_ready = 1'b1;
    drive('1, word_of(8'd41));
    sb.push_back(word_of(8'd41));
    tick(); idle();
    drain("drain_full_rw");
    check_eq("full_rw_no_ovf", 32'(bus.ovf_err), 0);

    // 20 words with ready toggling; pointers wrap
    do_flush();
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      bus.word_ready = (c % 2 == 0);
      if (c % 2 == 0) begin
        drive('1, word_of(8'(c / 2)));
        sb.push_back(word_of(8'(c / 2)));
      end else begin
        idle();
      end
      tick();
    end
    idle();
    drain("drain_stream");
    check_eq("stream_count", n_acc, 20);
    check_eq("stream_no_ovf", 32'(bus.ovf_err), 0);
    check_eq("stream_no_skew", 32'(bus.skew_err), 0);

    // Asynchronous reset with words buffered in RUN
    do_flush();
    bus.word_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive('1, word_of(8'(50 + k)));
      tick();
    end
    idle();
    tick();
    check_eq("pre_rst_aligned", 32'(bus.aligned), 1);
    check_eq("pre_rst_valid", 32'(bus.word_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_word_valid", 32'(bus.word_valid), 0);
    check_eq("arst_word_data", 32'(bus.word_data), 0);
    check_eq("arst_aligned", 32'(bus.aligned), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus.word_ready = 1'b1;
    d = word_of(8'd60);
    drive('1, d);
    sb.push_back(d);
    @(negedge clk) check_eq("post_rst_c0_valid", 32'(bus.word_valid), 0);
    tick(); idle();
    @(negedge clk) check_eq("post_rst_c1_valid", 32'(bus.word_valid), 0);
    tick();
    @(negedge clk) check_eq("post_rst_c2_valid", 32'(bus.word_valid), 1);
    drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_deskew_rx.md
LANE_DESKEW_RX -- requirements
Module: lane_deskew_rx

Interface
REQ-001 Parameter LANES, 6, number of 2-bit lanes.
REQ-002 Parameter LANE_W, 2, bits per lane.
REQ-003 Parameter DEPTH, 8, per-lane FIFO entries (power of two, >= MAX_SKEW+2).
REQ-004 Parameter MAX_SKEW, 4, max cycles allowed between first and last lane arrival.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous and active-low.
REQ-007 lane_data  input  LANES*LANE_W  lane i at bits [i*LANE_W +: LANE_W].
REQ-008 lane_valid  input  LANES  per-lane data strobe; no backpressure to lanes.
REQ-009 flush  input  1  synchronous clear of FIFOs, error and state.
REQ-010 word_data  output  LANES*LANE_W  aligned word; lane i at same bit position as input.
REQ-011 word_valid  output  1  word_data holds an aligned word.
REQ-012 word_ready  input  1  downstream accepts word when word_valid && word_ready.
REQ-013 aligned  output  1  high while state is RUN.
REQ-014 skew_err  output  1  sticky; lanes failed to align within MAX_SKEW.
REQ-015 ovf_err  output  LANES  sticky per lane; write attempted to full FIFO.

Function
REQ-016 Each lane SHALL have an independent FIFO of DEPTH entries; lane_valid[i] high at an edge writes lane i's data unless that FIFO is full.
REQ-017 Write to full FIFO i SHALL drop the data, set ovf_err[i], and force state ERR.
REQ-018 States SHALL be IDLE, WAIT, RUN, ERR; reset and flush enter IDLE.
REQ-019 IDLE -> WAIT at the edge where any lane_valid is high; skew_cnt cleared to 0.
REQ-020 WAIT: if all FIFOs non-empty -> RUN at that edge; else skew_cnt increments; if skew_cnt == MAX_SKEW and not all non-empty -> ERR.
REQ-021 A pop SHALL occur when state is WAIT or RUN, all FIFOs non-empty, and output register empty or being accepted this cycle; a pop reads one entry from every FIFO into word_data and sets word_valid.
REQ-022 word_valid SHALL clear after acceptance with no concurrent pop; word_data SHALL be stable while word_valid && !word_ready.
REQ-023 Latency: all lanes presenting data in cycle t with free output register and idle FIFOs SHALL give word_valid in cycle t+2.
REQ-024 RUN with some FIFOs empty SHALL simply stall (no error); lane order within a FIFO preserved.
REQ-025 ERR: no pops, no writes, word_valid cleared; left only by flush or reset.
REQ-026 flush SHALL take priority over all other events in the same cycle, empty all FIFOs, clear word_valid, skew_err, ovf_err, and enter IDLE; lane_valid in the flush cycle is discarded.
REQ-027 Simultaneous pop and write to the same FIFO SHALL both succeed, including when full (pop frees the slot).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-029 skew_err SHALL set on the WAIT->ERR transition only.

Reset
REQ-030 While rst_n low: state IDLE, FIFOs empty, word_valid 0, word_data 0, aligned 0, skew_err 0, ovf_err 0, skew_cnt 0.
REQ-031 Reset assertion mid-operation SHALL immediately discard all buffered data; first edge after release behaves as IDLE.

Verification
REQ-032 All 6 lanes valid in cycle 0 with data 2'b01,2'b10,2'b11,2'b00,2'b01,2'b10 (lane 0..5), word_ready=1 -> word_valid in cycle 2, word_data=12'b10_01_00_11_10_01, aligned=1.
REQ-033 Lanes 0-3 valid at cycle 0, lanes 4-5 at cycle 1 (each one word) -> no error; single word valid in cycle 3 with all six lane values.
REQ-034 Lane 5 never valid after lanes 0-4 at cycle 0, MAX_SKEW=4 -> skew_err=1 and state ERR after 4 WAIT cycles; word_valid never asserted; flush clears skew_err.
REQ-035 In RUN, word_ready=0, lane 2 valid 9 consecutive cycles with others valid 8 -> ovf_err=6'b000100, ERR, word_valid 0.
REQ-036 Continuous 20 words on all lanes with word_ready toggling 1,0 -> 20 words out in order, no duplicates, no errors, pointers wrap twice.
REQ-037 rst_n pulsed low during RUN with 3 words buffered -> all outputs at reset values asynchronously; next all-lane word appears with latency 2.
